// File: rtl/immed_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes an immediate from the instruction word,
// extends it to XLEN and registers it behind a valid/ready handshake, with an optional skid entry.
module immed_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_immed,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [XLEN-1:0]  imm_d;
  logic             ill_d;
  logic             main_valid_q;
  logic [XLEN-1:0]  main_imm_q;
  logic [TAG_W-1:0] main_tag_q;
  logic             main_ill_q;
  logic             in_fire;
  logic             out_fire;
  logic             unused_opcode;

  // Opcode bits never contribute to any immediate.
  assign unused_opcode = ^in_inst[6:0];

  always_comb begin
    imm_d = '0;
    ill_d = 1'b0;
    case (in_type)
      3'd0: imm_d = XLEN'($signed(in_inst[31:20]));
      3'd1: imm_d = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      3'd2: imm_d = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
      3'd3: imm_d = XLEN'($signed({in_inst[31:12], 12'b0}));
      3'd4: imm_d = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
      3'd5: imm_d = XLEN'(in_inst[19:15]);
      3'd6: imm_d = (XLEN == 64) ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
      default: ill_d = 1'b1;
    endcase
  end

  assign out_fire = main_valid_q && out_ready;
  // Flush wins over a concurrent input handshake: the word is dropped.
  assign in_fire  = in_valid && in_ready && !flush;

  generate
    if (SKID != 0) begin : g_skid
      logic             rdy_q;
      logic [XLEN-1:0]  skid_imm_q;
      logic [TAG_W-1:0] skid_tag_q;
      logic             skid_ill_q;

      // rdy_q low means the skid entry holds a result.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          main_valid_q <= 1'b0;
          main_imm_q   <= '0;
          main_tag_q   <= '0;
          main_ill_q   <= 1'b0;
          skid_imm_q   <= '0;
          skid_tag_q   <= '0;
          skid_ill_q   <= 1'b0;
          rdy_q        <= 1'b1;
        end else if (flush) begin
          main_valid_q <= 1'b0;
          rdy_q        <= 1'b1;
        end else if (!main_valid_q || out_fire) begin
          if (!rdy_q) begin
            main_valid_q <= 1'b1;
            main_imm_q   <= skid_imm_q;
            main_tag_q   <= skid_tag_q;
            main_ill_q   <= skid_ill_q;
            rdy_q        <= 1'b1;
          end else if (in_fire) begin
            main_valid_q <= 1'b1;
            main_imm_q   <= imm_d;
            main_tag_q   <= in_tag;
            main_ill_q   <= ill_d;
          end else begin
            main_valid_q <= 1'b0;
          end
        end else if (in_fire) begin
          skid_imm_q <= imm_d;
          skid_tag_q <= in_tag;
          skid_ill_q <= ill_d;
          rdy_q      <= 1'b0;
        end
      end

      assign in_ready = rdy_q;
    end else begin : g_noskid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          main_valid_q <= 1'b0;
          main_imm_q   <= '0;
          main_tag_q   <= '0;
          main_ill_q   <= 1'b0;
        end else if (flush) begin
          main_valid_q <= 1'b0;
        end else if (in_fire) begin
          main_valid_q <= 1'b1;
          main_imm_q   <= imm_d;
          main_tag_q   <= in_tag;
          main_ill_q   <= ill_d;
        end else if (out_fire) begin
          main_valid_q <= 1'b0;
        end
      end

      assign in_ready = !main_valid_q || out_ready;
    end
  endgenerate

  assign out_valid   = main_valid_q;
  assign out_immed   = main_imm_q;
  assign out_tag     = main_tag_q;
  assign out_illegal = main_ill_q;

endmodule
